// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer master: one valid/ready command becomes one bus cycle and one response.
// Bus cycles are bounded by an ack timeout so a dead slave cannot stall the command source.
module wb_cmd_master #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_BITS       = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [31:0]         cmd_adr,
    input  logic [31:0]         cmd_dat,
    input  logic [3:0]          cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [31:0]         rsp_dat,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [3:0]          wbm_sel_o,
    output logic [31:0]         wbm_adr_o,
    output logic [31:0]         wbm_dat_o,
    input  logic [31:0]         wbm_dat_i,
    input  logic                wbm_ack_i,
    input  logic                wbm_err_i,
    output logic [CNT_BITS-1:0] txn_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [15:0]         TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    logic [1:0]  state;
    logic [15:0] to_cnt;
    logic        bus_done;

    assign cmd_ready = (state == S_IDLE);

    // The bus phase ends on ERR, ACK, or expiry; ACK/ERR in the expiry cycle still yields a normal answer.
    assign bus_done = (state == S_BUS) && (wbm_err_i || wbm_ack_i || (to_cnt == TO_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            to_cnt <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        state <= S_BUS;
                        to_cnt <= 16'd0;
                    end
                end
                S_BUS: begin
                    if (bus_done) begin
                        state <= S_RESP;
                    end else if (to_cnt != 16'hFFFF) begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bus outputs are loaded on acceptance, held through the cycle, and zeroed when it ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'd0;
            wbm_adr_o <= 32'd0;
            wbm_dat_o <= 32'd0;
        end else if (state == S_IDLE && cmd_valid) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= cmd_we;
            wbm_sel_o <= cmd_sel;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
        end else if (bus_done) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'd0;
            wbm_adr_o <= 32'd0;
            wbm_dat_o <= 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid   <= 1'b0;
            rsp_dat     <= 32'd0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            txn_count   <= '0;
        end else if (bus_done) begin
            rsp_valid <= 1'b1;
            if (wbm_err_i) begin
                rsp_dat     <= 32'd0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b0;
            end else if (wbm_ack_i) begin
                rsp_dat     <= wbm_we_o ? 32'd0 : wbm_dat_i;
                rsp_err     <= 1'b0;
                rsp_timeout <= 1'b0;
            end else begin
                rsp_dat     <= 32'd0;
                rsp_err     <= 1'b0;
                rsp_timeout <= 1'b1;
            end
        end else if (state == S_RESP && rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_dat     <= 32'd0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            txn_count   <= txn_count + CNT_ONE;
        end
    end

endmodule
